// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register
// offsets, STATUS layout and default vector placement.
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intr_state_e;

    localparam int ID_W = 3;

    localparam logic [1:0] REG_PEND   = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_INSERV = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int STATUS_STATE_LSB = 8;
    localparam int STATUS_ID_LSB    = 0;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0008;
    localparam int          DEF_VEC_STRIDE = 8;

    function automatic logic [31:0] status_word(intr_state_e st, logic [ID_W-1:0] id);
        logic [31:0] w;
        w = '0;
        w[STATUS_STATE_LSB +: 2] = st;
        w[STATUS_ID_LSB +: ID_W] = id;
        return w;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 is the most urgent source.
module intr_prio_enc
    import intr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    active,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        valid = |active;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (active[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: latches, masks and prioritises sources,
// presents one request plus vector to the CPU. Define INTC_LEVEL_EN for level mode.
module intr_controller
    import intr_pkg::*;
#(
    parameter int               NSRC       = 4,
    parameter logic [31:0]      VEC_BASE   = DEF_VEC_BASE,
    parameter int               VEC_STRIDE = DEF_VEC_STRIDE,
    parameter logic [NSRC-1:0]  MASK_RESET = '1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [1:0]      reg_addr,
    input  logic            reg_we,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic            irq,
    output logic [31:0]     irq_vector,
    input  logic            irq_ack,
    input  logic            irq_eoi
);

    intr_state_e     state, state_next;
    logic [NSRC-1:0] pend, mask, inserv, active, sel_onehot;
    logic [ID_W-1:0] sel_id, sel_next, win_id;
    logic            win_valid, irq_next, take_ack, take_eoi, mask_wr;
    logic [31:0]     vec_next;
    logic            unused_wdata;

    assign mask_wr      = reg_we && (reg_addr == REG_MASK);
    assign active       = pend & mask;
    assign sel_onehot   = NSRC'(1) << sel_id;
    assign unused_wdata = ^reg_wdata[31:NSRC];

    intr_prio_enc #(.N(NSRC)) u_prio (
        .active (active),
        .valid  (win_valid),
        .id     (win_id)
    );

    // irq is a level held with a stable vector until the CPU takes it (irq_ack)
    // or the source loses its enable; irq_eoi later closes the service window.
    always_comb begin
        state_next = state;
        sel_next   = sel_id;
        irq_next   = irq;
        vec_next   = irq_vector;
        take_ack   = 1'b0;
        take_eoi   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_next = ST_REQ;
                    sel_next   = win_id;
                    irq_next   = 1'b1;
                    vec_next   = VEC_BASE + 32'(win_id) * 32'(VEC_STRIDE);
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    take_ack   = 1'b1;
                    state_next = ST_SERVICE;
                    irq_next   = 1'b0;
                end else if (!(|(active & sel_onehot))) begin
                    state_next = ST_IDLE;
                    irq_next   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (irq_eoi) begin
                    take_eoi   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                irq_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            sel_id     <= '0;
            irq        <= 1'b0;
            irq_vector <= VEC_BASE;
        end else begin
            state      <= state_next;
            sel_id     <= sel_next;
            irq        <= irq_next;
            irq_vector <= vec_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask   <= MASK_RESET;
            inserv <= '0;
        end else begin
            if (mask_wr) mask <= reg_wdata[NSRC-1:0];
            if (take_ack)      inserv <= inserv | sel_onehot;
            else if (take_eoi) inserv <= inserv & ~sel_onehot;
        end
    end

`ifdef INTC_LEVEL_EN
    always_ff @(posedge clock) begin
        if (reset) pend <= '0;
        else       pend <= irq_src;
    end
`else
    logic [NSRC-1:0] src_q, pend_set, pend_clr;
    logic            pend_wr;

    assign pend_wr  = reg_we && (reg_addr == REG_PEND);
    assign pend_set = irq_src & ~src_q;
    // A fresh edge beats a simultaneous ack or write-1-to-clear.
    assign pend_clr = (take_ack ? sel_onehot : '0) | (pend_wr ? reg_wdata[NSRC-1:0] : '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            src_q <= '0;
            pend  <= '0;
        end else begin
            src_q <= irq_src;
            pend  <= (pend & ~pend_clr) | pend_set;
        end
    end
`endif

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            REG_PEND:   reg_rdata = 32'(pend);
            REG_MASK:   reg_rdata = 32'(mask);
            REG_INSERV: reg_rdata = 32'(inserv);
            REG_STATUS: reg_rdata = status_word(state, sel_id);
            default:    reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: directed scenarios plus randomized traffic checked
// against a source-index-level reference model.
module tb_intr_controller;

    localparam int NSRC = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic [1:0]      reg_addr;
    logic            reg_we;
    logic [31:0]     reg_wdata;
    logic [31:0]     reg_rdata;
    logic            irq;
    logic [31:0]     irq_vector;
    logic            irq_ack;
    logic            irq_eoi;

    int n_vec = 0;
    int n_bad = 0;

    intr_controller dut (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .reg_addr   (reg_addr),
        .reg_we     (reg_we),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .irq        (irq),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi)
    );

    always #5 clock = ~clock;

    // Reference model: which source is presented / in service, as plain indices.
    int        m_pres = -1;
    int        m_srv  = -1;
    int        m_sel  = 0;
    logic [3:0]  m_pend = '0, m_mask = '1, m_inserv = '0, m_prev = '0;
    logic [31:0] m_vec = 32'h8;

    always @(posedge clock) begin
        logic [3:0] act, clr, nxt;
        if (reset) begin
            m_pres = -1; m_srv = -1; m_sel = 0;
            m_pend = '0; m_mask = '1; m_inserv = '0; m_prev = '0; m_vec = 32'h8;
        end else begin
            act = m_pend & m_mask;
            clr = '0;
            if (m_pres >= 0 && irq_ack) clr[m_pres] = 1'b1;
            if (reg_we && reg_addr == 2'd0) clr = clr | reg_wdata[3:0];
`ifdef INTC_LEVEL_EN
            nxt = irq_src;
`else
            nxt = (m_pend & ~clr) | (irq_src & ~m_prev);
`endif
            if (m_pres >= 0) begin
                if (irq_ack) begin
                    m_inserv[m_pres] = 1'b1;
                    m_srv = m_pres;
                    m_pres = -1;
                end else if (!act[m_pres]) begin
                    m_pres = -1;
                end
            end else if (m_srv >= 0) begin
                if (irq_eoi) begin
                    m_inserv[m_srv] = 1'b0;
                    m_srv = -1;
                end
            end else if (act != 0) begin
                for (int i = 3; i >= 0; i--) if (act[i]) m_pres = i;
                m_sel = m_pres;
                m_vec = 32'h8 + 32'(m_pres) * 32'd8;
            end
            if (reg_we && reg_addr == 2'd1) m_mask = reg_wdata[3:0];
            m_prev = irq_src;
            m_pend = nxt;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_we = 1'b0; reg_wdata = '0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %0b want 0", irq); end
        n_vec++; if (irq_vector !== 32'h8) begin n_bad++; $display("FAIL reset_vec: got %h want 00000008", irq_vector); end
        read_reg(2'd0, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_pend: got %h want 0", d); end
        read_reg(2'd1, d);
        n_vec++; if (d !== 32'hF) begin n_bad++; $display("FAIL reset_mask: got %h want f", d); end
        read_reg(2'd2, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_inserv: got %h want 0", d); end
        read_reg(2'd3, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        irq_src = 4'b0010; tick(); irq_src = '0;
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL single_early_irq: got %0b want 0", irq); end
        read_reg(2'd0, d);
        n_vec++; if (d !== 32'h2) begin n_bad++; $display("FAIL single_pend: got %h want 2", d); end
        tick();
        n_vec++; if (irq !== 1'b1) begin n_bad++; $display("FAIL single_irq: got %0b want 1", irq); end
        n_vec++; if (irq_vector !== 32'h10) begin n_bad++; $display("FAIL single_vec: got %h want 10", irq_vector); end
        pulse_ack();
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL single_ack_irq: got %0b want 0", irq); end
        read_reg(2'd0, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL single_ack_pend: got %h want 0", d); end
        read_reg(2'd2, d);
        n_vec++; if (d !== 32'h2) begin n_bad++; $display("FAIL single_inserv: got %h want 2", d); end
        read_reg(2'd3, d);
        n_vec++; if (d !== 32'h201) begin n_bad++; $display("FAIL single_status_srv: got %h want 201", d); end
        pulse_eoi();
        read_reg(2'd2, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL single_eoi_inserv: got %h want 0", d); end
        read_reg(2'd3, d);
        n_vec++; if (d !== 32'h001) begin n_bad++; $display("FAIL single_eoi_status: got %h want 1", d); end
        tick();
    endtask

    task automatic test_simultaneous();
        irq_src = 4'b0101; tick(); irq_src = '0; tick();
        n_vec++; if (irq !== 1'b1 || irq_vector !== 32'h8) begin n_bad++; $display("FAIL simul_first: got irq=%0b vec=%h want 1/00000008", irq, irq_vector); end
        pulse_ack();
        pulse_eoi();
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL simul_gap: got %0b want 0", irq); end
        tick();
        n_vec++; if (irq !== 1'b1 || irq_vector !== 32'h18) begin n_bad++; $display("FAIL simul_second: got irq=%0b vec=%h want 1/00000018", irq, irq_vector); end
        pulse_ack();
        pulse_eoi();
        tick();
    endtask

    task automatic test_mask();
        logic [31:0] d;
        write_reg(2'd1, 32'hE);
        irq_src = 4'b0001; tick(); irq_src = '0; tick(); tick();
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mask_blocked_irq: got %0b want 0", irq); end
        read_reg(2'd0, d);
        n_vec++; if (d !== 32'h1) begin n_bad++; $display("FAIL mask_pend: got %h want 1", d); end
        write_reg(2'd1, 32'hF);
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mask_old_value: got %0b want 0", irq); end
        tick();
        n_vec++; if (irq !== 1'b1 || irq_vector !== 32'h8) begin n_bad++; $display("FAIL mask_release: got irq=%0b vec=%h want 1/00000008", irq, irq_vector); end
        pulse_ack();
        pulse_eoi();
        tick();
    endtask

    task automatic test_drop();
        logic [31:0] d;
        irq_src = 4'b1000; tick(); irq_src = '0; tick();
        n_vec++; if (irq !== 1'b1 || irq_vector !== 32'h20) begin n_bad++; $display("FAIL drop_req: got irq=%0b vec=%h want 1/00000020", irq, irq_vector); end
        write_reg(2'd0, 32'h8);
        tick();
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL drop_irq: got %0b want 0", irq); end
        read_reg(2'd3, d);
        n_vec++; if (d !== 32'h003) begin n_bad++; $display("FAIL drop_status: got %h want 3", d); end
        read_reg(2'd2, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL drop_inserv: got %h want 0", d); end
        tick();
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL drop_stays_low: got %0b want 0", irq); end
    endtask

    task automatic test_spurious();
        logic [31:0] d;
        irq_src = 4'b0001; tick(); irq_src = '0; tick();
        pulse_ack();
        irq_src = 4'b0010; tick(); irq_src = '0;
        pulse_ack();
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL spur_irq: got %0b want 0", irq); end
        read_reg(2'd0, d);
        n_vec++; if (d !== 32'h2) begin n_bad++; $display("FAIL spur_pend: got %h want 2", d); end
        read_reg(2'd2, d);
        n_vec++; if (d !== 32'h1) begin n_bad++; $display("FAIL spur_inserv: got %h want 1", d); end
        pulse_eoi();
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL spur_gap: got %0b want 0", irq); end
        tick();
        n_vec++; if (irq !== 1'b1 || irq_vector !== 32'h10) begin n_bad++; $display("FAIL spur_next: got irq=%0b vec=%h want 1/00000010", irq, irq_vector); end
        pulse_ack();
        pulse_eoi();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        irq_src = 4'b0001; tick(); irq_src = '0; tick();
        pulse_ack();
        irq_src = 4'b0010; tick(); irq_src = '0;
        write_reg(2'd1, 32'h3);
        reset = 1'b1; tick(); reset = 1'b0;
        n_vec++; if (irq !== 1'b0 || irq_vector !== 32'h8) begin n_bad++; $display("FAIL rst_mid_out: got irq=%0b vec=%h want 0/00000008", irq, irq_vector); end
        read_reg(2'd0, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mid_pend: got %h want 0", d); end
        read_reg(2'd1, d);
        n_vec++; if (d !== 32'hF) begin n_bad++; $display("FAIL rst_mid_mask: got %h want f", d); end
        read_reg(2'd2, d);
        n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_mid_inserv: got %h want 0", d); end
        tick(); tick();
        n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_mid_lost: got %0b want 0", irq); end
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        int          st;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NSRC; b++) if ($urandom_range(0, 3) == 0) irq_src[b] = ~irq_src[b];
            irq_ack   = ($urandom_range(0, 3) == 0);
            irq_eoi   = ($urandom_range(0, 3) == 0);
            reg_we    = ($urandom_range(0, 7) == 0);
            reg_addr  = 2'($urandom_range(0, 3));
            reg_wdata = $urandom;
            reset     = ($urandom_range(0, 399) == 0);
            tick();
            st = (m_pres >= 0) ? 1 : ((m_srv >= 0) ? 2 : 0);
            case (reg_addr)
                2'd0:    exp_rd = 32'(m_pend);
                2'd1:    exp_rd = 32'(m_mask);
                2'd2:    exp_rd = 32'(m_inserv);
                default: exp_rd = (32'(st) << 8) | 32'(m_sel);
            endcase
            n_vec++; if (irq !== (m_pres >= 0)) begin n_bad++; $display("FAIL rand_irq cyc %0d: got %0b want %0b", c, irq, (m_pres >= 0)); end
            n_vec++; if (irq_vector !== m_vec) begin n_bad++; $display("FAIL rand_vec cyc %0d: got %h want %h", c, irq_vector, m_vec); end
            n_vec++; if (reg_rdata !== exp_rd) begin n_bad++; $display("FAIL rand_rdata cyc %0d addr %0d: got %h want %h", c, reg_addr, reg_rdata, exp_rd); end
        end
        irq_src = '0; irq_ack = 1'b0; irq_eoi = 1'b0; reg_we = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_src = '0; reg_addr = '0; reg_we = 1'b0;
        reg_wdata = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
        test_reset();
`ifndef INTC_LEVEL_EN
        test_single();
        test_simultaneous();
        test_mask();
        test_drop();
        test_spurious();
        test_reset_mid();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
- Memory-mapped interrupt controller between the peripheral interrupt sources (timer, keyboard, others) and the single-cycle CPU's interrupt input.
- Latches requests, applies a software mask and picks the highest-priority source. It presents one request plus a vector to the CPU and tracks the in-service source until the CPU signals end-of-interrupt (eret).
- Its registers sit in the I/O space (a000_0000–bfff_ffff) decoded upstream.

Parameters:
- NSRC, 4, number of interrupt sources (1..8); index 0 is highest priority.
- VEC_BASE, 32'h0000_0008, vector of source 0.
- VEC_STRIDE, 8, byte spacing between vectors: j + nop slot per source, giving 0x08, 0x10, 0x18, ...
- MASK_RESET, all ones, reset value of the MASK register.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- irq_src  in  NSRC  raw interrupt request lines
- reg_addr  in  2  register select (word address bits [3:2])
- reg_we  in  1  register write strobe (one cycle)
- reg_wdata  in  32  register write data
- reg_rdata  out  32  register read data, combinational from reg_addr
- irq  out  1  interrupt request to CPU, registered
- irq_vector  out  32  handler address for the current request, registered
- irq_ack  in  1  CPU took the interrupt (one-cycle pulse, same cycle it loads pc with the vector)
- irq_eoi  in  1  CPU executed eret (one-cycle pulse)

Behaviour:
- Reset: PEND=0, MASK=MASK_RESET, INSERV=0, state=IDLE, sel_id=0, irq=0, irq_vector=VEC_BASE, src_q=0.
- Request capture (default, edge mode):
  - src_q registers irq_src each cycle.
  - pending[i] sets when irq_src[i] & ~src_q[i].
  - pending[i] clears on an ack of source i, or on a write-1-to-clear to PEND.
  - Set and clear in the same cycle: set wins.
- active = PEND & MASK. Priority = lowest set index of active.
- FSM:
  - IDLE: if active != 0 -> REQ; latch sel_id = priority winner; irq_vector <= VEC_BASE + sel_id*VEC_STRIDE; irq <= 1.
  - REQ: irq held at 1, vector held stable (no re-arbitration, even if a higher-priority request arrives).
    - irq_ack -> SERVICE: clear pending[sel_id], set INSERV[sel_id], irq <= 0.
    - Without ack, if active[sel_id] drops (software masked or cleared it) -> IDLE with irq <= 0.
    - ack takes precedence over the drop in the same cycle.
  - SERVICE: irq=0. Further requests keep latching in PEND but are not presented.
    - irq_eoi -> IDLE and clear INSERV[sel_id].
    - If other sources are active, the next request asserts irq two cycles after eoi (IDLE then REQ).
- irq_ack outside REQ and irq_eoi outside SERVICE: ignored.
- Latency: edge on irq_src in cycle t -> pending visible t+1 -> irq=1 at t+2.
- Register map (reg_addr):
  - 0 PEND: read pending; write 1 clears bit.
  - 1 MASK: read/write, 1 = enabled.
  - 2 INSERV: read only.
  - 3 STATUS: read only, {state[1:0] at bits 9:8, sel_id at bits 2:0}.
  - Unused upper bits read 0; writes to read-only registers are ignored.
- MASK write in the same cycle as the IDLE arbitration: arbitration uses the old MASK value.
- Reset asserted mid-service: everything returns to reset values. Requests still pending are lost unless their source produces a new edge.

Optional Feature:
- INTC_LEVEL_EN.
  - Defined: level mode. pending[i] = irq_src[i] registered each cycle; ack and write-1-to-clear have no effect; the source must deassert its line itself. Latency edge->irq drops to... level high at t -> irq at t+2 (unchanged).
  - Undefined: edge mode as above.

Decomposition:
- Package intr_pkg: FSM state encoding (IDLE=0, REQ=1, SERVICE=2), register offsets (PEND/MASK/INSERV/STATUS), STATUS bit positions, default VEC_BASE/VEC_STRIDE.
- One sub-module: intr_prio_enc, a parameterised lowest-index priority encoder (active -> valid, id).

Test Plan:
- Reset then pulse irq_src[1] for 1 cycle -> irq=1 two cycles later, irq_vector=0x10; ack -> irq=0, PEND=0, INSERV=0x2; eoi -> INSERV=0, STATUS state=IDLE.
- irq_src[2] and irq_src[0] rise in the same cycle -> vector 0x08 first; after ack+eoi, irq reasserts two cycles later with vector 0x18.
- Write MASK=0xE, pulse irq_src[0] -> irq stays 0, PEND=0x1; write MASK=0xF -> irq=1 two cycles later, vector 0x08.
- In REQ for source 3, software writes PEND=0x8 (clear) -> irq drops next cycle, FSM returns to IDLE, no INSERV bit set.
- During SERVICE of source 0, pulse irq_src[1]; spurious ack -> ignored, irq stays 0; eoi -> irq=1 with vector 0x10.
- Assert reset while in SERVICE -> irq=0, PEND=0, INSERV=0, MASK=0xF, vector=0x08 on the next edge.
